// File: rtl/data_ctrl_pkg.sv
// Shared types and constants for the cache data-array sequencer.
package data_ctrl_pkg;

  localparam int IDX_W      = 5;   // 32 sets
  localparam int LINE_WORDS = 4;   // 32-bit words per 128-bit line
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } fill_state_e;

  // Place a word's 4 byte strobes into the 16 per-byte write enables of a line.
  function automatic logic [15:0] expand_wstrb(input logic [1:0] off,
                                               input logic [3:0] wstrb);
    return 16'(wstrb) << {off, 2'b00};
  endfunction

endpackage

// File: rtl/fill_line_buf.sv
// Refill beat collector: stores four 32-bit beats in order and flags the last one.
module fill_line_buf
  import data_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           valid,
  input  logic                           ready,
  input  logic [WORD_W-1:0]              data,
  output logic                           accept,
  output logic                           full,
  output logic [LINE_WORDS*WORD_W-1:0]   line
);

  logic [LINE_WORDS-1:0][WORD_W-1:0] words;
  logic [1:0]                        cnt;

  assign accept = valid & ready;
  // Asserted together with the handshake of the fourth beat.
  assign full   = accept & (cnt == 2'd3);
  assign line   = words;

  // Beat counter and buffer; each accepted beat lands in the word it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      // NOTE: the buffer is reset on purpose so a dropped refill never leaves stale beats visible.
      words <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      words[cnt] <= data;
      cnt        <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/data_array_ctrl.sv
// Shares the 2-way cache data array between the core port and the line refill port.
module data_array_ctrl #(
  parameter int IDX_W      = data_ctrl_pkg::IDX_W,
  parameter int LINE_WORDS = data_ctrl_pkg::LINE_WORDS
) (
  input  logic                       CK,
  input  logic                       RSTn,
  input  logic                       core_req,
  input  logic                       core_we,
  input  logic [IDX_W-1:0]           core_idx,
  input  logic                       core_way,
  input  logic [1:0]                 core_off,
  input  logic [3:0]                 core_wstrb,
  input  logic [31:0]                core_wdata,
  output logic                       core_gnt,
  output logic                       core_rvalid,
  output logic [31:0]                core_rdata,
  input  logic                       fill_start,
  input  logic [IDX_W-1:0]           fill_idx,
  input  logic                       fill_way,
  input  logic                       fill_valid,
  input  logic [31:0]                fill_data,
  output logic                       fill_ready,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       arr_CS,
  output logic                       arr_OE,
  output logic [IDX_W-1:0]           arr_A,
  output logic [15:0]                arr_WEB1,
  output logic [15:0]                arr_WEB2,
  output logic [LINE_WORDS*32-1:0]   arr_DI,
  input  logic [LINE_WORDS*32-1:0]   arr_DO1,
  input  logic [LINE_WORDS*32-1:0]   arr_DO2
);

  data_ctrl_pkg::fill_state_e state;

  logic [IDX_W-1:0]          fill_idx_q;
  logic                      fill_way_q;
  logic                      buf_clear;
  logic                      buf_full;
  logic                      beat_accept;
  logic [LINE_WORDS*32-1:0]  line;

  logic                      rd_pending;
  logic                      rd_way;
  logic [1:0]                rd_off;
  logic [LINE_WORDS*32-1:0]  rd_line;
  logic [15:0]               store_web;

  assign fill_ready = (state == data_ctrl_pkg::COLLECT);
  assign fill_busy  = (state != data_ctrl_pkg::IDLE);
  assign buf_clear  = (state == data_ctrl_pkg::IDLE) & fill_start;

  // The line being refilled is off limits to the core until it has been written.
  assign core_gnt = core_req & (state != data_ctrl_pkg::WRITE) &
                    !((state == data_ctrl_pkg::COLLECT) &
                      (core_idx == fill_idx_q) & (core_way == fill_way_q));

  assign store_web = data_ctrl_pkg::expand_wstrb(core_off, core_wstrb);

  fill_line_buf u_line_buf (
    .clk    (CK),
    .rst_n  (RSTn),
    .clear  (buf_clear),
    .valid  (fill_valid),
    .ready  (fill_ready),
    .data   (fill_data),
    .accept (beat_accept),
    .full   (buf_full),
    .line   (line)
  );

  // Refill sequencer: collect four beats, write the line in one cycle, then pulse done.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= data_ctrl_pkg::IDLE;
      fill_idx_q <= '0;
      fill_way_q <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      fill_done <= (state == data_ctrl_pkg::WRITE);
      case (state)
        data_ctrl_pkg::IDLE: begin
          if (fill_start) begin
            fill_idx_q <= fill_idx;
            fill_way_q <= fill_way;
            state      <= data_ctrl_pkg::COLLECT;
          end
        end
        data_ctrl_pkg::COLLECT: if (buf_full) state <= data_ctrl_pkg::WRITE;
        data_ctrl_pkg::WRITE:   state <= data_ctrl_pkg::IDLE;
        default:                state <= data_ctrl_pkg::IDLE;
      endcase
    end
  end

  // Array command mux: the refill write owns the array in WRITE, else a granted core access.
  always_comb begin
    // NOTE: every output gets a default first so no path through the mux infers a latch.
    arr_CS   = 1'b0;
    arr_OE   = 1'b0;
    arr_A    = '0;
    arr_WEB1 = '0;
    arr_WEB2 = '0;
    arr_DI   = '0;
    if (state == data_ctrl_pkg::WRITE) begin
      arr_CS = 1'b1;
      arr_A  = fill_idx_q;
      arr_DI = line;
      if (fill_way_q) arr_WEB2 = 16'hFFFF;
      else            arr_WEB1 = 16'hFFFF;
    end else if (core_gnt) begin
      arr_CS = 1'b1;
      arr_A  = core_idx;
      if (!core_we) begin
        arr_OE = 1'b1;
      end else begin
        arr_DI = {LINE_WORDS{core_wdata}};
        if (core_way) arr_WEB2 = store_web;
        else          arr_WEB1 = store_web;
      end
    end
  end

  // Remember which way/word a granted load wants so the next cycle can pick it out.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      rd_pending <= 1'b0;
      rd_way     <= 1'b0;
      rd_off     <= '0;
    end else begin
      rd_pending <= core_gnt & !core_we;
      if (core_gnt & !core_we) begin
        rd_way <= core_way;
        rd_off <= core_off;
      end
    end
  end

  // Load return: array data arrives one cycle after issue; forced to zero when not valid.
  assign rd_line     = rd_way ? arr_DO2 : arr_DO1;
  assign core_rvalid = rd_pending;
  assign core_rdata  = rd_pending ? rd_line[{rd_off, 5'b00000} +: 32] : 32'h0;

endmodule

// File: tb/tb_data_array_ctrl.sv
// Self-checking bench: behavioural array plus a word-level reference of cache contents.
module tb_data_array_ctrl;

  logic         CK = 1'b0;
  logic         RSTn = 1'b0;
  logic         core_req, core_we, core_way;
  logic [4:0]   core_idx;
  logic [1:0]   core_off;
  logic [3:0]   core_wstrb;
  logic [31:0]  core_wdata;
  logic         core_gnt, core_rvalid;
  logic [31:0]  core_rdata;
  logic         fill_start, fill_way, fill_valid;
  logic [4:0]   fill_idx;
  logic [31:0]  fill_data;
  logic         fill_ready, fill_busy, fill_done;
  logic         arr_CS, arr_OE;
  logic [4:0]   arr_A;
  logic [15:0]  arr_WEB1, arr_WEB2;
  logic [127:0] arr_DI, arr_DO1, arr_DO2;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] amem [2][32];     // the physical array, driven only by DUT pins
  logic [31:0]  rmem [2][32][4];  // what each cached word should hold

  data_array_ctrl dut (
    .CK(CK), .RSTn(RSTn),
    .core_req(core_req), .core_we(core_we), .core_idx(core_idx), .core_way(core_way),
    .core_off(core_off), .core_wstrb(core_wstrb), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .fill_start(fill_start), .fill_idx(fill_idx), .fill_way(fill_way),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .arr_CS(arr_CS), .arr_OE(arr_OE), .arr_A(arr_A), .arr_WEB1(arr_WEB1),
    .arr_WEB2(arr_WEB2), .arr_DI(arr_DI), .arr_DO1(arr_DO1), .arr_DO2(arr_DO2)
  );

  always #5 CK = ~CK;

  // Array model: registered read, per-byte write.
  always @(posedge CK) begin
    if (arr_CS) begin
      if (arr_OE) begin
        arr_DO1 <= amem[0][arr_A];
        arr_DO2 <= amem[1][arr_A];
      end else begin
        for (int k = 0; k < 16; k++) begin
          if (arr_WEB1[k]) amem[0][arr_A][8*k +: 8] <= arr_DI[8*k +: 8];
          if (arr_WEB2[k]) amem[1][arr_A][8*k +: 8] <= arr_DI[8*k +: 8];
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    core_req = 0; core_we = 0; core_idx = 0; core_way = 0; core_off = 0;
    core_wstrb = 0; core_wdata = 0;
    fill_start = 0; fill_idx = 0; fill_way = 0; fill_valid = 0; fill_data = 0;
  endtask

  task automatic next_cycle();
    @(posedge CK); #1;
    idle_in();
  endtask

  task automatic set_load(input logic [4:0] idx, input logic way, input logic [1:0] off);
    core_req = 1; core_we = 0; core_idx = idx; core_way = way; core_off = off;
  endtask

  task automatic do_load(input logic [4:0] idx, input logic way, input logic [1:0] off);
    next_cycle();
    set_load(idx, way, off);
    @(negedge CK);
    check("load_gnt", core_gnt, 1'b1);
    check("load_cs_oe", {arr_CS, arr_OE}, 2'b11);
    check("load_addr", arr_A, idx);
    next_cycle();
    @(negedge CK);
    check("load_rvalid", core_rvalid, 1'b1);
    check("load_rdata", core_rdata, rmem[way][idx][off]);
  endtask

  task automatic do_store(input logic [4:0] idx, input logic way, input logic [1:0] off,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    logic [15:0] exp_web;
    for (int k = 0; k < 16; k++) exp_web[k] = ((k / 4) == off) && wstrb[k % 4];
    next_cycle();
    core_req = 1; core_we = 1; core_idx = idx; core_way = way; core_off = off;
    core_wstrb = wstrb; core_wdata = wdata;
    @(negedge CK);
    check("store_gnt", core_gnt, 1'b1);
    check("store_cs_oe", {arr_CS, arr_OE}, 2'b10);
    check("store_addr", arr_A, idx);
    check("store_web_sel", way ? arr_WEB2 : arr_WEB1, exp_web);
    check("store_web_other", way ? arr_WEB1 : arr_WEB2, 16'h0);
    check("store_di", arr_DI, {4{wdata}});
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) rmem[way][idx][off][8*b +: 8] = wdata[8*b +: 8];
    next_cycle();
    @(negedge CK);
    check("store_no_rvalid", {core_rvalid, core_rdata}, 33'h0);
  endtask

  task automatic do_refill(input logic [4:0] idx, input logic way);
    logic [31:0] beats [4];
    next_cycle();
    fill_start = 1; fill_idx = idx; fill_way = way;
    @(negedge CK);
    check("refill_idle_busy", fill_busy, 1'b0);
    for (int n = 0; n < 4; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        next_cycle();
        @(negedge CK);
        check("refill_gap_ready", fill_ready, 1'b1);
      end
      beats[n] = $urandom;
      next_cycle();
      fill_valid = 1; fill_data = beats[n];
      @(negedge CK);
      check("refill_beat_ready", {fill_ready, fill_busy}, 2'b11);
    end
    next_cycle();
    @(negedge CK);
    check("refill_wr_cs_oe", {arr_CS, arr_OE}, 2'b10);
    check("refill_wr_addr", arr_A, idx);
    check("refill_wr_web", {arr_WEB2, arr_WEB1}, way ? 32'hFFFF_0000 : 32'h0000_FFFF);
    check("refill_wr_di", arr_DI, {beats[3], beats[2], beats[1], beats[0]});
    for (int n = 0; n < 4; n++) rmem[way][idx][n] = beats[n];
    next_cycle();
    @(negedge CK);
    check("refill_done", {fill_done, fill_busy}, 2'b10);
  endtask

  initial begin
    logic [31:0] a [4];
    idle_in();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 32; i++)
        for (int n = 0; n < 4; n++) begin
          rmem[w][i][n] = $urandom;
          amem[w][i][32*n +: 32] = rmem[w][i][n];
        end
    amem[1][5][95:64] = 32'hCAFEBABE;
    rmem[1][5][2]     = 32'hCAFEBABE;

    // Reset state
    repeat (2) @(posedge CK);
    @(negedge CK);
    check("reset_outputs", {core_rvalid, core_rdata, fill_ready, fill_busy, fill_done}, 36'h0);
    check("reset_array_idle", {arr_CS, arr_OE, arr_WEB1, arr_WEB2}, 34'h0);
    @(posedge CK); #1 RSTn = 1;

    // Directed load and store
    do_load(5'd5, 1'b1, 2'd2);
    do_store(5'd3, 1'b0, 2'd1, 4'b0101, 32'h11223344);
    do_load(5'd3, 1'b0, 2'd1);
    do_store(5'd3, 1'b0, 2'd1, 4'b0000, 32'hDEADBEEF);
    do_load(5'd3, 1'b0, 2'd1);

    // Back-to-back loads
    next_cycle(); set_load(5'd10, 1'b0, 2'd0);
    @(negedge CK); check("b2b_gnt0", core_gnt, 1'b1);
    next_cycle(); set_load(5'd11, 1'b1, 2'd3);
    @(negedge CK);
    check("b2b_gnt1", core_gnt, 1'b1);
    check("b2b_rdata0", {core_rvalid, core_rdata}, {1'b1, rmem[0][10][0]});
    next_cycle();
    @(negedge CK); check("b2b_rdata1", {core_rvalid, core_rdata}, {1'b1, rmem[1][11][3]});

    // Refill 7/1 with gaps, same-line stall, other-way grant, ignored second start
    a[0] = 32'hA0A0_0000; a[1] = 32'hA1A1_1111; a[2] = 32'hA2A2_2222; a[3] = 32'hA3A3_3333;
    next_cycle(); fill_start = 1; fill_idx = 5'd7; fill_way = 1'b1;
    @(negedge CK); check("fill_start_busy", fill_busy, 1'b0);
    next_cycle(); fill_valid = 1; fill_data = a[0];
    @(negedge CK); check("collect_flags", {fill_ready, fill_busy}, 2'b11);
    next_cycle(); fill_valid = 1; fill_data = a[1];
    next_cycle(); set_load(5'd7, 1'b1, 2'd0); fill_start = 1; fill_idx = 5'd9; fill_way = 1'b0;
    @(negedge CK); check("conflict_stall", core_gnt, 1'b0);
    next_cycle(); set_load(5'd7, 1'b0, 2'd3);
    @(negedge CK); check("other_way_gnt", core_gnt, 1'b1);
    next_cycle(); set_load(5'd7, 1'b1, 2'd1); fill_valid = 1; fill_data = a[2];
    @(negedge CK);
    check("other_way_rdata", {core_rvalid, core_rdata}, {1'b1, rmem[0][7][3]});
    check("conflict_stall2", core_gnt, 1'b0);
    next_cycle(); set_load(5'd7, 1'b1, 2'd1); fill_valid = 1; fill_data = a[3];
    @(negedge CK); check("conflict_stall3", {core_gnt, core_rvalid}, 2'b00);
    next_cycle(); set_load(5'd7, 1'b1, 2'd1);
    @(negedge CK);
    check("write_collision_gnt", core_gnt, 1'b0);
    check("write_cs_oe", {arr_CS, arr_OE}, 2'b10);
    check("write_addr", arr_A, 5'd7);
    check("write_web", {arr_WEB2, arr_WEB1}, 32'hFFFF_0000);
    check("write_di", arr_DI, {a[3], a[2], a[1], a[0]});
    for (int n = 0; n < 4; n++) rmem[1][7][n] = a[n];
    next_cycle(); set_load(5'd7, 1'b1, 2'd1);
    @(negedge CK);
    check("post_write_gnt", core_gnt, 1'b1);
    check("fill_done_pulse", {fill_done, fill_busy}, 2'b10);
    next_cycle();
    @(negedge CK);
    check("post_write_rdata", {core_rvalid, core_rdata}, {1'b1, a[1]});
    check("fill_done_clear", {fill_done, fill_busy}, 2'b00);

    // Reset in the middle of a refill drops it
    next_cycle(); fill_start = 1; fill_idx = 5'd12; fill_way = 1'b0;
    next_cycle(); fill_valid = 1; fill_data = 32'h5555_5555;
    next_cycle(); fill_valid = 1; fill_data = 32'h6666_6666;
    next_cycle();
    #1 RSTn = 0;
    #1 check("reset_mid_refill", {fill_busy, fill_ready, arr_CS, core_rvalid}, 4'b0000);
    @(posedge CK); #1 RSTn = 1;
    do_load(5'd12, 1'b0, 2'd0);
    do_load(5'd12, 1'b0, 2'd1);
    do_refill(5'd12, 1'b0);
    do_load(5'd12, 1'b0, 2'd1);

    // Randomized mix of loads, stores and refills
    for (int t = 0; t < 120; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5)
        do_load(5'($urandom), 1'($urandom), 2'($urandom));
      else if (kind < 9)
        do_store(5'($urandom), 1'($urandom), 2'($urandom),
                 (kind == 8) ? 4'b0000 : 4'($urandom), $urandom);
      else
        do_refill(5'($urandom), 1'($urandom));
    end

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_array_ctrl.md
# data_array_ctrl

Sequencer and arbiter for the 2-way, 32-set, 128-bit-line cache data array. It shares the array between two requesters: the core port, which does single-word reads and byte-masked stores on hits, and the refill port, which collects a four-beat line from memory and writes it in one array cycle. It sits between the cache FSM/memory interface and the data array wrapper. It generates CS/OE/A/WEB1/WEB2/DI and returns way/word-selected read data one cycle after issue.

## Interface
Parameters:
- IDX_W, 5, set index width (32 sets)
- LINE_WORDS, 4, 32-bit words per line (fixed; 128-bit line)

Ports:
- CK  in  1  clock
- RSTn  in  1  asynchronous, active-low reset
- core_req  in  1  core access request
- core_we  in  1  1 = store, 0 = load
- core_idx  in  IDX_W  set index
- core_way  in  1  target way (0 → WEB1/DO1, 1 → WEB2/DO2)
- core_off  in  2  word offset in line
- core_wstrb  in  4  byte strobes for store
- core_wdata  in  32  store data
- core_gnt  out  1  request accepted this cycle (combinational)
- core_rvalid  out  1  load data valid
- core_rdata  out  32  load data
- fill_start  in  1  begin refill (sampled only when fill_busy=0)
- fill_idx  in  IDX_W  refill set
- fill_way  in  1  refill way
- fill_valid  in  1  refill beat valid
- fill_data  in  32  refill beat
- fill_ready  out  1  beat accepted when fill_valid & fill_ready
- fill_busy  out  1  refill in progress
- fill_done  out  1  one-cycle pulse, line written
- arr_CS, arr_OE  out  1 each  array chip select / read enable
- arr_A  out  IDX_W  array address
- arr_WEB1, arr_WEB2  out  16 each  per-byte write enables, way 0/1; bit=1 writes that byte
- arr_DI  out  128  write data; byte k = DI[8k+7:8k], word w = DI[32w+31:32w]
- arr_DO1, arr_DO2  in  128 each  read data, way 0/1, valid one cycle after read issue

## Operation
- FSM states: IDLE, COLLECT, WRITE.
- IDLE: fill_start=1 latches fill_idx/fill_way, clears beat counter, moves to COLLECT. The core port is serviced in the same cycle.
- COLLECT: fill_ready=1. Each accepted beat n (n=0..3) is stored in word n of the line buffer. On the 4th beat, move to WRITE.
- WRITE: arr_CS=1, arr_OE=0, arr_A=fill_idx. The selected way's WEB is 16'hFFFF and the other is 0. arr_DI = line buffer. Then return to IDLE. fill_done pulses in the following cycle.
- fill_busy=1 in COLLECT and WRITE.
- core_gnt = core_req & state≠WRITE & !(state==COLLECT & core_idx==fill_idx & core_way==fill_way). A same-line access during refill stalls.
- Granted load: arr_CS=1, arr_OE=1, arr_A=core_idx. core_way and core_off are registered.
- Next cycle after a load: core_rvalid=1, core_rdata = word core_off of DO1 (way 0) or DO2 (way 1).
- Granted store: arr_CS=1, arr_OE=0, arr_A=core_idx. The selected way's WEB bits [4·off+3:4·off] = core_wstrb; all other WEB bits are 0. arr_DI = core_wdata replicated into all 4 words. No rvalid is generated.
- No access: arr_CS=arr_OE=0, arr_A=0, WEB=0, DI=0.
- A store with core_wstrb=0 is granted and performs no write.
- Reset (async, any state): state=IDLE, beat counter and line buffer cleared. core_rvalid, core_rdata, fill_ready, fill_busy and fill_done are 0. An in-flight refill is dropped with no array write.

## Timing
- Load latency: grant in cycle t, core_rvalid/core_rdata in t+1. Loads may be back-to-back every cycle.
- Store: written at the CK edge ending the grant cycle. A load to the same word granted in t+1 returns the new data in t+2.
- Refill: minimum 4 COLLECT cycles + 1 WRITE cycle. fill_done follows one cycle after WRITE. A new fill_start is accepted the cycle fill_done is high.
- fill_start while fill_busy=1 is ignored.
- fill_valid gaps are allowed; the counter advances only on handshake.
- Simultaneous core_req and WRITE: the core waits exactly one cycle.
- core_rdata is 0 whenever core_rvalid=0.

## Structure
- Package data_ctrl_pkg holds: the state enum (IDLE/COLLECT/WRITE), LINE_WORDS, IDX_W, and a byte-strobe expansion function (word offset + wstrb → 16-bit WEB).
- One sub-module, fill_line_buf: 4×32 beat buffer with a 2-bit counter, beat-accept and full flag.
- data_array_wrapper is instantiated by the parent, not inside this block.

## Test plan
- Load: core_req, we=0, idx=5, way=1, off=2 with DO2[95:64]=32'hCAFEBABE → rvalid next cycle, rdata=32'hCAFEBABE, arr_A=5, CS=OE=1.
- Store: idx=3, way=0, off=1, wstrb=4'b0101, wdata=32'h11223344 → WEB1=16'h0050, WEB2=0, DI[63:32]=32'h11223344, OE=0.
- Refill: fill_start idx=7, way=1, then beats A0..A3 with a 2-cycle gap after beat 1 → WRITE cycle shows WEB2=16'hFFFF, DI={A3,A2,A1,A0}, A=7; fill_done pulses one cycle later.
- Conflict: during COLLECT for idx=7/way=1, a core load to 7/1 → gnt=0 until after WRITE. A load to 7/0 in the same period → granted.
- WRITE collision: core_req asserted in the WRITE cycle → gnt=0, granted next cycle. A second fill_start during busy is ignored.
- Reset mid-refill: RSTn low after 2 beats → fill_busy=0, no array write. A new refill afterward completes with correct data.
